// File: rtl/io_ctrl.sv
// io_ctrl -- peripheral-side I/O controller for the processor I/O port.
//
// Every processor input address owns a small first-word-fall-through FIFO.
// An external valid/ready producer fills it, and processor reads (req_in)
// drain it. Every processor output address owns a FIFO. Processor writes
// (out_en) fill it, and an external valid/ready consumer drains it. An
// interrupt pulse is raised when input data arrives in an empty channel.
//
// Optional feature macro: IO_ITR_EN
//   defined   : itr pulses for one cycle after any input channel goes from
//               empty to non-empty
//   undefined : itr is tied to 0 and no edge-detect logic is built
//
// Ports
//   clk            rising-edge clock
//   rst            synchronous, active-high reset
//   req_in         processor read strobe; pops channel addr_in
//   addr_in        processor read address
//   io_in          head of channel addr_in (0 when that channel is empty)
//   out_en         processor write strobe
//   addr_out       processor write address
//   io_out         processor write data
//   itr            interrupt pulse to the processor
//   ext_in_data    producer data; channel k at [k*NUBITS +: NUBITS]
//   ext_in_valid   producer valid, one bit per channel
//   ext_in_ready   input FIFO not full, one bit per channel
//   ext_out_data   consumer data; channel j at [j*NUBITS +: NUBITS]
//   ext_out_valid  output FIFO not empty, one bit per channel
//   ext_out_ready  consumer accept, one bit per channel
//   in_udf         sticky: read seen on an empty input channel
//   out_ovf        sticky: write dropped on a full output channel
module io_ctrl #(
  parameter int unsigned NUBITS = 16,
  parameter int unsigned NUIOIN = 2,
  parameter int unsigned NUIOOU = 2,
  parameter int unsigned FDEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_in,
  input  logic [$clog2(NUIOIN)-1:0]  addr_in,
  output logic [NUBITS-1:0]          io_in,
  input  logic                       out_en,
  input  logic [$clog2(NUIOOU)-1:0]  addr_out,
  input  logic [NUBITS-1:0]          io_out,
  output logic                       itr,
  input  logic [NUIOIN*NUBITS-1:0]   ext_in_data,
  input  logic [NUIOIN-1:0]          ext_in_valid,
  output logic [NUIOIN-1:0]          ext_in_ready,
  output logic [NUIOOU*NUBITS-1:0]   ext_out_data,
  output logic [NUIOOU-1:0]          ext_out_valid,
  input  logic [NUIOOU-1:0]          ext_out_ready,
  output logic [NUIOIN-1:0]          in_udf,
  output logic [NUIOOU-1:0]          out_ovf
);

  localparam int unsigned AIW = $clog2(NUIOIN);
  localparam int unsigned AOW = $clog2(NUIOOU);
  localparam int unsigned PW  = $clog2(FDEPTH);
  localparam int unsigned CW  = $clog2(FDEPTH) + 1;

  // ---------------------------------------------------------------------
  // Input channel storage
  // ---------------------------------------------------------------------
  logic [NUBITS-1:0] r_in_mem [NUIOIN][FDEPTH];
  logic [PW-1:0]     r_in_wp  [NUIOIN];
  logic [PW-1:0]     r_in_rp  [NUIOIN];
  logic [CW-1:0]     r_in_cnt [NUIOIN];
  logic [NUIOIN-1:0] r_in_udf;

  logic [NUIOIN-1:0] w_in_sel;
  logic [NUIOIN-1:0] w_in_full;
  logic [NUIOIN-1:0] w_in_empty;
  logic [NUIOIN-1:0] w_in_push;
  logic [NUIOIN-1:0] w_in_pop;
  logic [NUIOIN-1:0] w_in_udf;

  // ---------------------------------------------------------------------
  // Output channel storage
  // ---------------------------------------------------------------------
  logic [NUBITS-1:0] r_out_mem [NUIOOU][FDEPTH];
  logic [PW-1:0]     r_out_wp  [NUIOOU];
  logic [PW-1:0]     r_out_rp  [NUIOOU];
  logic [CW-1:0]     r_out_cnt [NUIOOU];
  logic [NUIOOU-1:0] r_out_ovf;

  logic [NUIOOU-1:0] w_out_sel;
  logic [NUIOOU-1:0] w_out_full;
  logic [NUIOOU-1:0] w_out_empty;
  logic [NUIOOU-1:0] w_out_drain;
  logic [NUIOOU-1:0] w_out_wr;
  logic [NUIOOU-1:0] w_out_ovf;

  // ---------------------------------------------------------------------
  // Input side: handshake decode and FWFT read mux.
  // An address that matches no channel selects nothing: no pop, no flag,
  // and io_in stays 0.
  // ---------------------------------------------------------------------
  always_comb begin
    w_in_sel   = '0;
    w_in_full  = '0;
    w_in_empty = '0;
    w_in_push  = '0;
    w_in_pop   = '0;
    w_in_udf   = '0;
    io_in      = '0;
    for (int unsigned k = 0; k < NUIOIN; k++) begin
      w_in_sel[k]   = (addr_in == AIW'(k));
      w_in_full[k]  = (r_in_cnt[k] == CW'(FDEPTH));
      w_in_empty[k] = (r_in_cnt[k] == '0);
      // Ready is not pop-aware, so a full channel refuses a push even
      // when the processor is reading it in the same cycle.
      w_in_push[k]  = ext_in_valid[k] & ~w_in_full[k];
      w_in_pop[k]   = req_in & w_in_sel[k] & ~w_in_empty[k];
      w_in_udf[k]   = req_in & w_in_sel[k] &  w_in_empty[k];
      if (w_in_sel[k] && !w_in_empty[k]) begin
        io_in = r_in_mem[k][r_in_rp[k]];
      end
    end
  end

  assign ext_in_ready = ~w_in_full;
  assign in_udf       = r_in_udf;

  // Payload storage carries no reset; emptiness is tracked by the counts.
  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < NUIOIN; k++) begin
      if (!rst && w_in_push[k]) begin
        r_in_mem[k][r_in_wp[k]] <= ext_in_data[k*NUBITS +: NUBITS];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < NUIOIN; k++) begin
        r_in_wp[k]  <= '0;
        r_in_rp[k]  <= '0;
        r_in_cnt[k] <= '0;
      end
      r_in_udf <= '0;
    end else begin
      for (int unsigned k = 0; k < NUIOIN; k++) begin
        if (w_in_push[k]) begin
          r_in_wp[k] <= r_in_wp[k] + PW'(1);
        end
        if (w_in_pop[k]) begin
          r_in_rp[k] <= r_in_rp[k] + PW'(1);
        end
        r_in_cnt[k] <= r_in_cnt[k] + CW'(w_in_push[k]) - CW'(w_in_pop[k]);
      end
      r_in_udf <= r_in_udf | w_in_udf;
    end
  end

  // ---------------------------------------------------------------------
  // Output side: a full channel still accepts a write when the consumer
  // drains it in the same cycle.
  // ---------------------------------------------------------------------
  always_comb begin
    w_out_sel     = '0;
    w_out_full    = '0;
    w_out_empty   = '0;
    w_out_drain   = '0;
    w_out_wr      = '0;
    w_out_ovf     = '0;
    ext_out_data  = '0;
    for (int unsigned j = 0; j < NUIOOU; j++) begin
      w_out_sel[j]   = (addr_out == AOW'(j));
      w_out_full[j]  = (r_out_cnt[j] == CW'(FDEPTH));
      w_out_empty[j] = (r_out_cnt[j] == '0);
      w_out_drain[j] = ~w_out_empty[j] & ext_out_ready[j];
      w_out_wr[j]    = out_en & w_out_sel[j] & (~w_out_full[j] | w_out_drain[j]);
      w_out_ovf[j]   = out_en & w_out_sel[j] &   w_out_full[j] & ~w_out_drain[j];
      ext_out_data[j*NUBITS +: NUBITS] = r_out_mem[j][r_out_rp[j]];
    end
  end

  assign ext_out_valid = ~w_out_empty;
  assign out_ovf       = r_out_ovf;

  always_ff @(posedge clk) begin
    for (int unsigned j = 0; j < NUIOOU; j++) begin
      if (!rst && w_out_wr[j]) begin
        r_out_mem[j][r_out_wp[j]] <= io_out;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned j = 0; j < NUIOOU; j++) begin
        r_out_wp[j]  <= '0;
        r_out_rp[j]  <= '0;
        r_out_cnt[j] <= '0;
      end
      r_out_ovf <= '0;
    end else begin
      for (int unsigned j = 0; j < NUIOOU; j++) begin
        if (w_out_wr[j]) begin
          r_out_wp[j] <= r_out_wp[j] + PW'(1);
        end
        if (w_out_drain[j]) begin
          r_out_rp[j] <= r_out_rp[j] + PW'(1);
        end
        r_out_cnt[j] <= r_out_cnt[j] + CW'(w_out_wr[j]) - CW'(w_out_drain[j]);
      end
      r_out_ovf <= r_out_ovf | w_out_ovf;
    end
  end

  // ---------------------------------------------------------------------
  // Interrupt. An empty channel cannot pop, so a push into an empty channel
  // is exactly the 0->nonzero count transition. Registering that event
  // places the pulse in the first cycle the new word is visible; several
  // channels filling at once OR into a single pulse.
  // ---------------------------------------------------------------------
`ifdef IO_ITR_EN
  logic r_itr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_itr <= 1'b0;
    end else begin
      r_itr <= |(w_in_push & w_in_empty);
    end
  end

  assign itr = r_itr;
`else
  assign itr = 1'b0;
`endif

endmodule
